bus_mux_reg: RTL and testbench

- Parametrised, registered successor to the datapath bus multiplexer: N sources of W bits, each with its own select strobe, drive a shared registered Bus.
- Adds one-cycle registered output and a valid flag.
- Adds multi-select (conflict) detection with a configurable resolution mode, a sticky error flag and a saturating conflict counter.
- Sits between the register file/ALU result/Din sources and the processor bus consumers.

---
 rtl/bus_mux_reg.sv | 102 ++++++++++
 tb/tb_bus_mux_reg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_mux_reg.sv
// Registered N-source bus multiplexer with one-hot select strobes.
// A single asserted select loads its source onto the bus one cycle later.
// Two or more asserted selects are a conflict. The conflict is resolved either
// by lowest index or by blocking the update, and it is recorded in a pulse, a
// sticky flag and a saturating counter.
module bus_mux_reg #(
  parameter int W             = 16,
  parameter int N             = 10,
  parameter bit HOLD_LAST     = 1'b1,
  parameter bit CONFLICT_MODE = 1'b0,
  parameter int CNT_W         = 8,
  localparam int IDX_W        = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*W-1:0]     src_data,
  input  logic [N-1:0]       src_sel,
  input  logic               err_clr,
  output logic [W-1:0]       bus,
  output logic               bus_valid,
  output logic [IDX_W-1:0]   src_idx,
  output logic               conflict,
  output logic               err_sticky,
  output logic [CNT_W-1:0]   conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             any_sel;
  logic             multi_sel;
  logic [IDX_W-1:0] low_idx;
  logic [W-1:0]     low_data;
  logic             load_en;

  // Classify the select vector (none / one / several) and find the lowest
  // asserted source. The loop only visits indices 0..N-1, so an index of N
  // or above can never be produced, whatever N is.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
    any_sel   = 1'b0;
    multi_sel = 1'b0;
    low_idx   = '0;
    low_data  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (src_sel[i]) begin
        low_idx  = IDX_W'(i);
        low_data = src_data[i*W +: W];
      end
    end
    for (int i = 0; i < N; i++) begin
      multi_sel = multi_sel | (any_sel & src_sel[i]);
      any_sel   = any_sel | src_sel[i];
    end
  end

  // The bus loads on a clean single select. In lowest-index mode it also
  // loads on a conflict.
  assign load_en = any_sel && (!multi_sel || !CONFLICT_MODE);

  // Bus datapath: load the resolved source, hold it, or clear it when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus       <= '0;
      bus_valid <= 1'b0;
      src_idx   <= '0;
    end else if (load_en) begin
      // NOTE: sequential state uses non-blocking assignments, so all registers update together from pre-edge values.
      bus       <= low_data;
      src_idx   <= low_idx;
      bus_valid <= 1'b1;
    end else begin
      bus_valid <= 1'b0;
      if (!any_sel && !HOLD_LAST) begin
        bus <= '0;
      end
    end
  end

  // Conflict bookkeeping. A conflict in the same cycle as a clear wins, so
  // the counter restarts at one instead of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict     <= 1'b0;
      err_sticky   <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      conflict <= multi_sel;
      if (multi_sel) begin
        err_sticky <= 1'b1;
        if (err_clr) begin
          conflict_cnt <= CNT_W'(1);
        end else if (conflict_cnt != CNT_MAX) begin
          conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
      end else if (err_clr) begin
        err_sticky   <= 1'b0;
        conflict_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bus_mux_reg.sv
// Self-checking bench for bus_mux_reg. Two instances share the stimulus:
// dut_a uses the defaults (hold last value, lowest-index resolution, 8-bit
// counter). dut_b clears the bus when idle, blocks the update on a conflict
// and has a 2-bit counter. Each instance is compared against its own
// behavioural model.
module tb_bus_mux_reg;

  localparam int W = 16;
  localparam int N = 10;

  typedef struct {
    logic [15:0] bus;
    logic        valid;
    logic [3:0]  idx;
    logic        conflict;
    logic        sticky;
    int          cnt;
  } state_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   src_sel;
  logic           err_clr;

  logic [15:0] a_bus, b_bus;
  logic        a_valid, b_valid;
  logic [3:0]  a_idx, b_idx;
  logic        a_conf, b_conf;
  logic        a_sticky, b_sticky;
  logic [7:0]  a_cnt;
  logic [1:0]  b_cnt;

  logic [15:0] srcv [N];
  state_t      ma, mb;
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  bus_mux_reg #(.W(W), .N(N), .HOLD_LAST(1'b1), .CONFLICT_MODE(1'b0), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .src_data(src_data), .src_sel(src_sel), .err_clr(err_clr),
    .bus(a_bus), .bus_valid(a_valid), .src_idx(a_idx), .conflict(a_conf),
    .err_sticky(a_sticky), .conflict_cnt(a_cnt)
  );

  bus_mux_reg #(.W(W), .N(N), .HOLD_LAST(1'b0), .CONFLICT_MODE(1'b1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .src_data(src_data), .src_sel(src_sel), .err_clr(err_clr),
    .bus(b_bus), .bus_valid(b_valid), .src_idx(b_idx), .conflict(b_conf),
    .err_sticky(b_sticky), .conflict_cnt(b_cnt)
  );

  function automatic state_t zero_state();
    state_t s;
    s.bus = '0; s.valid = 1'b0; s.idx = '0; s.conflict = 1'b0; s.sticky = 1'b0; s.cnt = 0;
    return s;
  endfunction

  // Reference behaviour: gather the selected indices in ascending order, then
  // apply the rules for none / one / several selects.
  function automatic state_t model(state_t s, bit hold_last, bit block_mode, int cnt_max,
                                   logic [N-1:0] sel, bit clr);
    state_t r = s;
    int     q[$];
    for (int i = 0; i < N; i++) if (sel[i]) q.push_back(i);
    if (q.size() == 0) begin
      r.valid = 1'b0;
      r.conflict = 1'b0;
      if (!hold_last) r.bus = '0;
    end else if (q.size() == 1 || !block_mode) begin
      r.bus = srcv[q[0]];
      r.idx = 4'(q[0]);
      r.valid = 1'b1;
      r.conflict = (q.size() > 1);
    end else begin
      r.valid = 1'b0;
      r.conflict = 1'b1;
    end
    if (q.size() > 1) begin
      r.sticky = 1'b1;
      r.cnt = clr ? 1 : ((s.cnt + 1 > cnt_max) ? cnt_max : s.cnt + 1);
    end else if (clr) begin
      r.sticky = 1'b0;
      r.cnt = 0;
    end
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_all(string step_tag);
    check({step_tag, " a.bus"},      32'(a_bus),    32'(ma.bus));
    check({step_tag, " a.valid"},    32'(a_valid),  32'(ma.valid));
    check({step_tag, " a.idx"},      32'(a_idx),    32'(ma.idx));
    check({step_tag, " a.conflict"}, 32'(a_conf),   32'(ma.conflict));
    check({step_tag, " a.sticky"},   32'(a_sticky), 32'(ma.sticky));
    check({step_tag, " a.cnt"},      32'(a_cnt),    32'(ma.cnt));
    check({step_tag, " b.bus"},      32'(b_bus),    32'(mb.bus));
    check({step_tag, " b.valid"},    32'(b_valid),  32'(mb.valid));
    check({step_tag, " b.idx"},      32'(b_idx),    32'(mb.idx));
    check({step_tag, " b.conflict"}, 32'(b_conf),   32'(mb.conflict));
    check({step_tag, " b.sticky"},   32'(b_sticky), 32'(mb.sticky));
    check({step_tag, " b.cnt"},      32'(b_cnt),    32'(mb.cnt));
  endtask

  // Drive one cycle of inputs at the falling edge, then check 1 ns after the
  // rising edge.
  task automatic step(string step_tag, logic [N-1:0] sel, bit clr);
    @(negedge clk);
    for (int i = 0; i < N; i++) src_data[i*W +: W] = srcv[i];
    src_sel = sel;
    err_clr = clr;
    @(posedge clk);
    #1;
    ma = model(ma, 1'b1, 1'b0, 255, sel, clr);
    mb = model(mb, 1'b0, 1'b1, 3, sel, clr);
    check_all(step_tag);
  endtask

  initial begin
    logic [31:0] rv;
    for (int i = 0; i < N; i++) srcv[i] = 16'h1000 + 16'(i);
    src_data = '0;
    src_sel = '0;
    err_clr = 1'b0;
    rst = 1'b1;
    ma = zero_state();
    mb = zero_state();
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // One-hot sweep across all sources.
    for (int i = 0; i < N; i++) step("sweep", 10'(1 << i), 1'b0);
    check("sweep_end a.bus", 32'(a_bus), 32'h1009);

    // Idle after 0x1009: dut_a holds, dut_b clears.
    step("idle", '0, 1'b0);
    check("idle a.bus", 32'(a_bus), 32'h1009);
    check("idle b.bus", 32'(b_bus), 32'h0000);

    // Conflict on sources 2, 5 and 9.
    step("conf0", 10'b1000100100, 1'b0);
    check("conf0 a.bus", 32'(a_bus), 32'h1002);
    step("conf0_after", 10'b0000000100, 1'b0);

    // Blocked update in dut_b: load 3, then conflict on sources 4 and 5.
    step("load3", 10'b0000001000, 1'b0);
    step("conf1", 10'b0000110000, 1'b0);
    check("conf1 b.bus", 32'(b_bus), 32'h1003);
    check("conf1 b.idx", 32'(b_idx), 32'd3);

    // Five back-to-back conflicts saturate the 2-bit counter.
    for (int i = 0; i < 5; i++) step("sat", 10'b1111111111, 1'b0);
    check("sat b.cnt", 32'(b_cnt), 32'd3);

    // Clear with a single select, then clear together with a conflict.
    step("clr_onehot", 10'b0001000000, 1'b1);
    step("clr_conf", 10'b0000000011, 1'b1);
    check("clr_conf b.cnt", 32'(b_cnt), 32'd1);

    // Reset raised between edges while source 2 stays selected.
    step("pre_rst", 10'b0000000100, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    ma = zero_state();
    mb = zero_state();
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_held");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 10'b0000000100, 1'b0);
    check("post_rst a.bus", 32'(a_bus), 32'h1002);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic [N-1:0] sel;
      for (int i = 0; i < N; i++) begin
        rv = $urandom;
        srcv[i] = rv[15:0];
      end
      rv = $urandom;
      case ($urandom_range(0, 3))
        0:       sel = '0;
        1:       sel = 10'(1 << $urandom_range(0, N - 1));
        default: sel = rv[N-1:0];
      endcase
      step("rand", sel, ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
